instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address assigned to the first emitted instruction word.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous and active-high.
REQ-004 clear  in  1  synchronous restart.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  bundle accepted when in_valid and in_ready are high at the same edge.
REQ-007 op  in  5  mnemonic code.
REQ-008 rs, rt, rd, shamt  in  5 each  register and shift fields.
REQ-009 imm  in  16  immediate field.
REQ-010 target  in  26  jump target field.
REQ-011 out_valid  out  1  instr is valid.
REQ-012 out_ready  in  1  consumer (instruction-memory writer) ready.
REQ-013 instr  out  32  encoded MIPS word.
REQ-014 addr  out  32  byte address of the current instr.
REQ-015 count  out  16  number of words emitted.
REQ-016 err  out  1  sticky illegal-op flag.

Function
REQ-017 The op map SHALL be as follows, with R-type using opcode 000000 plus the listed func: 0 ADD 100000; 1 SUB 100010; 2 AND 100100; 3 OR 100101; 4 SLT 101010; 5 SLL 000000; 6 SRA 000011; 7 SLLV 000100; 8 JR 001000.
REQ-018 The op map SHALL continue with I/J opcodes: 9 ADDI 001000; 10 ORI 001101; 11 LW 100011; 12 SW 101011; 13 LUI 001111; 14 BEQ 000100; 15 BNE 000101; 16 J 000010; 17 JAL 000011. Codes 18-31 SHALL be illegal.
REQ-019 R-type SHALL be encoded as {000000, rs, rt, rd, shamt, func}.
REQ-020 R-type field forcing: SLL/SRA force rs=0; all other R ops force shamt=0; JR forces rt=rd=shamt=0.
REQ-021 I-type SHALL be encoded as {opcode, rs, rt, imm}; LUI forces rs=0.
REQ-022 J-type SHALL be encoded as {opcode, target}.
REQ-023 The output SHALL be a single-entry registered buffer with states EMPTY and FULL.
REQ-024 in_ready SHALL equal (state==EMPTY) or out_ready.
REQ-025 Latency: a legal bundle accepted at edge N SHALL appear on instr with out_valid=1 after edge N; throughput is 1 word/cycle while out_ready=1.
REQ-026 EMPTY->FULL SHALL occur on a legal accept.
REQ-027 FULL->EMPTY SHALL occur on an output handshake with no legal accept in the same edge.
REQ-028 FULL SHALL remain FULL on a simultaneous handshake plus legal accept, with the new word loaded.
REQ-029 While out_valid=1 and out_ready=0, instr and addr SHALL hold stable.
REQ-030 addr SHALL advance by 4 and count by 1 on each output handshake (out_valid & out_ready); both SHALL wrap modulo their width.
REQ-031 An illegal op SHALL be accepted (handshake completes) but produce no word, SHALL set err=1, and SHALL leave addr and count unchanged.
REQ-032 err SHALL remain 1 until clear or reset.
REQ-033 clear SHALL take priority over all handshakes: state becomes EMPTY, addr=BASE_ADDR, count=0, err=0, and the buffered word is discarded; in_ready=0 during a clear cycle.

Reset
REQ-034 Asserting reset SHALL immediately force out_valid=0, instr=0, addr=BASE_ADDR, count=0, err=0, and state EMPTY, including mid-stream; in_ready SHALL be 1 after reset deasserts.

Verification
REQ-035 ADD rs=1 rt=2 rd=3 -> instr 32'h00221820, addr 0; then ADDI rs=0 rt=8 imm=5 -> 32'h20080005, addr 4, count 2.
REQ-036 SLL rs=7 rt=1 rd=2 shamt=4 -> 32'h00011100 (rs forced 0); LW rs=29 rt=8 imm=16'hFFFC -> 32'h8FA8FFFC.
REQ-037 JAL target=26'h10 -> 32'h0C000010.
REQ-038 Hold out_ready=0 and offer two ops -> first word held stable, in_ready=0, second not accepted; release -> words at addr 0 and 4 in order, no loss or duplication.
REQ-039 op=20 -> no out_valid, err=1, addr unchanged; then clear -> err=0, addr=BASE_ADDR.
REQ-040 Assert reset while FULL with out_ready=0 -> out_valid=0 asynchronously; after release the first word appears at BASE_ADDR and count=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes MIPS instruction field bundles into 32-bit words with sequential byte addresses.
// Latency: one cycle, single-entry output buffer; stalls input while the buffer is full and unread.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic [15:0] count,
    output logic        err
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state_q, state_d;
    logic        legal;
    logic [31:0] enc_word;
    logic        accept;
    logic        load;
    logic        out_hs;

    // Field forcing is folded into each encoding so unused inputs never leak into the word.
    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (op)
            5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
            5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
            5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
            5'd5:  enc_word = {6'b000000, 5'd0, rt, rd, shamt, 6'b000000};
            5'd6:  enc_word = {6'b000000, 5'd0, rt, rd, shamt, 6'b000011};
            5'd7:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b000100};
            5'd8:  enc_word = {6'b000000, rs, 15'd0, 6'b001000};
            5'd9:  enc_word = {6'b001000, rs, rt, imm};
            5'd10: enc_word = {6'b001101, rs, rt, imm};
            5'd11: enc_word = {6'b100011, rs, rt, imm};
            5'd12: enc_word = {6'b101011, rs, rt, imm};
            5'd13: enc_word = {6'b001111, 5'd0, rt, imm};
            5'd14: enc_word = {6'b000100, rs, rt, imm};
            5'd15: enc_word = {6'b000101, rs, rt, imm};
            5'd16: enc_word = {6'b000010, target};
            5'd17: enc_word = {6'b000011, target};
            default: legal  = 1'b0;
        endcase
    end

    assign out_valid = (state_q == FULL);
    assign in_ready  = !clear && ((state_q == EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && legal;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (load) state_d = FULL;
                FULL:    if (out_hs && !load) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // addr tracks the buffered word; it moves on only once that word has been taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr <= '0;
            addr  <= BASE_ADDR;
            count <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            instr <= '0;
            addr  <= BASE_ADDR;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (load) begin
                instr <= enc_word;
            end
            if (out_hs) begin
                addr  <= addr + 32'd4;
                count <= count + 16'd1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, buffering, backpressure, errors, clear and reset.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int NV = 16;

    logic        clock = 1'b0;
    logic        reset, clear, in_valid, in_ready;
    logic [4:0]  op, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid, out_ready;
    logic [31:0] instr, addr;
    logic [15:0] count;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_count;

    // Encoding vectors: op, rs, rt, rd, shamt, imm, target -> expected word (hand-computed).
    logic [4:0]  v_op    [NV] = '{5'd5, 5'd11, 5'd17, 5'd1, 5'd6, 5'd8, 5'd13, 5'd15,
                                  5'd16, 5'd4, 5'd12, 5'd10, 5'd2, 5'd3, 5'd7, 5'd14};
    logic [4:0]  v_rs    [NV] = '{5'd7, 5'd29, 5'd3, 5'd4, 5'd3, 5'd31, 5'd3, 5'd1,
                                  5'd9, 5'd2, 5'd29, 5'd0, 5'd1, 5'd1, 5'd1, 5'd4};
    logic [4:0]  v_rt    [NV] = '{5'd1, 5'd8, 5'd3, 5'd5, 5'd9, 5'd5, 5'd4, 5'd2,
                                  5'd9, 5'd3, 5'd31, 5'd1, 5'd2, 5'd2, 5'd2, 5'd5};
    logic [4:0]  v_rd    [NV] = '{5'd2, 5'd31, 5'd3, 5'd6, 5'd10, 5'd6, 5'd9, 5'd9,
                                  5'd9, 5'd1, 5'd7, 5'd7, 5'd3, 5'd3, 5'd3, 5'd7};
    logic [4:0]  v_shamt [NV] = '{5'd4, 5'd31, 5'd3, 5'd7, 5'd31, 5'd7, 5'd9, 5'd9,
                                  5'd9, 5'd0, 5'd7, 5'd7, 5'd9, 5'd9, 5'd5, 5'd7};
    logic [15:0] v_imm   [NV] = '{16'h1111, 16'hFFFC, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h1234, 16'hFFFF,
                                  16'h7777, 16'h0, 16'h0008, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0010};
    logic [25:0] v_tgt   [NV] = '{26'h0, 26'h3FFFFFF, 26'h10, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0,
                                  26'h3FFFFFF, 26'h0, 26'h1, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0};
    logic [31:0] v_exp   [NV] = '{32'h00011100, 32'h8FA8FFFC, 32'h0C000010, 32'h00853022,
                                  32'h000957C3, 32'h03E00008, 32'h3C041234, 32'h1422FFFF,
                                  32'h0BFFFFFF, 32'h0043082A, 32'hAFBF0008, 32'h3401ABCD,
                                  32'h00221824, 32'h00221825, 32'h00221804, 32'h10850010};

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr), .count(count), .err(err)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [4:0] o, input logic [4:0] f_rs, input logic [4:0] f_rt,
                         input logic [4:0] f_rd, input logic [4:0] f_sh,
                         input logic [15:0] f_imm, input logic [25:0] f_tgt);
        op = o; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; imm = f_imm; target = f_tgt;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        repeat (2) @(negedge clock);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests_run++; if (instr !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: got %h want 0", instr); end
        tests_run++; if (addr !== BASE) begin tests_failed++; $display("FAIL rst_addr: got %h want %h", addr, BASE); end
        tests_run++; if (count !== 16'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", count); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", err); end
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        exp_addr = BASE; exp_count = 16'd0;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        tests_run++; if (out_valid !== 1'b1 || instr !== 32'h00221820) begin tests_failed++; $display("FAIL add_word: got vld=%b %h want vld=1 00221820", out_valid, instr); end
        tests_run++; if (addr !== BASE) begin tests_failed++; $display("FAIL add_addr: got %h want %h", addr, BASE); end
        drive(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'h0);
        @(negedge clock);
        exp_addr = exp_addr + 32'd4; exp_count = exp_count + 16'd1;
        tests_run++; if (out_valid !== 1'b1 || instr !== 32'h20080005) begin tests_failed++; $display("FAIL addi_word: got vld=%b %h want vld=1 20080005", out_valid, instr); end
        tests_run++; if (addr !== exp_addr) begin tests_failed++; $display("FAIL addi_addr: got %h want %h", addr, exp_addr); end
        in_valid = 1'b0;
        @(negedge clock);
        exp_addr = exp_addr + 32'd4; exp_count = exp_count + 16'd1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_vld: got %b want 0", out_valid); end
        tests_run++; if (count !== 16'd2) begin tests_failed++; $display("FAIL basic_count: got %0d want 2", count); end
        tests_run++; if (addr !== 32'h0) begin tests_failed++; $display("FAIL addr_wrap: got %h want 00000000", addr); end
    endtask

    task automatic test_encodings;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(v_op[i], v_rs[i], v_rt[i], v_rd[i], v_shamt[i], v_imm[i], v_tgt[i]);
            @(negedge clock);
            tests_run++;
            if (out_valid !== 1'b1 || instr !== v_exp[i] || addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL enc_op%0d: got vld=%b %h @%h want vld=1 %h @%h", v_op[i], out_valid, instr, addr, v_exp[i], exp_addr);
            end
            in_valid = 1'b0;
            @(negedge clock);
            exp_addr = exp_addr + 32'd4; exp_count = exp_count + 16'd1;
        end
        tests_run++; if (count !== exp_count) begin tests_failed++; $display("FAIL enc_count: got %0d want %0d", count, exp_count); end
    endtask

    task automatic test_backpressure;
        logic [31:0] a0;
        a0 = exp_addr;
        out_ready = 1'b0;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        drive(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'h0);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        repeat (3) @(negedge clock);
        tests_run++; if (out_valid !== 1'b1 || instr !== 32'h00221820 || addr !== a0) begin tests_failed++; $display("FAIL bp_hold: got vld=%b %h @%h want vld=1 00221820 @%h", out_valid, instr, addr, a0); end
        tests_run++; if (count !== exp_count) begin tests_failed++; $display("FAIL bp_count_hold: got %0d want %0d", count, exp_count); end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || instr !== 32'h20080005 || addr !== a0 + 32'd4) begin tests_failed++; $display("FAIL bp_second: got vld=%b %h @%h want vld=1 20080005 @%h", out_valid, instr, addr, a0 + 32'd4); end
        @(negedge clock);
        exp_addr = a0 + 32'd8; exp_count = exp_count + 16'd2;
        tests_run++; if (out_valid !== 1'b0 || count !== exp_count || addr !== exp_addr) begin tests_failed++; $display("FAIL bp_drain: got vld=%b cnt=%0d @%h want vld=0 cnt=%0d @%h", out_valid, count, addr, exp_count, exp_addr); end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        drive(5'd20, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ill_in_ready: got %b want 1", in_ready); end
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("FAIL ill_flag: got vld=%b err=%b want vld=0 err=1", out_valid, err); end
        tests_run++; if (addr !== exp_addr || count !== exp_count) begin tests_failed++; $display("FAIL ill_addr: got %h cnt=%0d want %h cnt=%0d", addr, count, exp_addr, exp_count); end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        drive(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        in_valid = 1'b0;
        exp_addr = exp_addr + 32'd4; exp_count = exp_count + 16'd1;
        tests_run++; if (out_valid !== 1'b0 || addr !== exp_addr || count !== exp_count) begin tests_failed++; $display("FAIL ill_full: got vld=%b @%h cnt=%0d want vld=0 @%h cnt=%0d", out_valid, addr, count, exp_addr, exp_count); end
        repeat (2) @(negedge clock);
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL ill_sticky: got %b want 1", err); end
    endtask

    task automatic test_clear;
        out_ready = 1'b0;
        drive(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        clear = 1'b1; out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
        @(negedge clock);
        clear = 1'b0; in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL clr_state: got vld=%b err=%b want vld=0 err=0", out_valid, err); end
        tests_run++; if (addr !== BASE || count !== 16'd0) begin tests_failed++; $display("FAIL clr_addr: got %h cnt=%0d want %h cnt=0", addr, count, BASE); end
        @(negedge clock);
        tests_run++; if (out_valid !== 1'b0 || count !== 16'd0) begin tests_failed++; $display("FAIL clr_discard: got vld=%b cnt=%0d want vld=0 cnt=0", out_valid, count); end
        exp_addr = BASE; exp_count = 16'd0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        drive(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || count !== 16'd1) begin tests_failed++; $display("FAIL mid_pre: got vld=%b cnt=%0d want vld=1 cnt=1", out_valid, count); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || instr !== 32'h0) begin tests_failed++; $display("FAIL mid_async: got vld=%b %h want vld=0 0", out_valid, instr); end
        tests_run++; if (addr !== BASE || count !== 16'd0) begin tests_failed++; $display("FAIL mid_async_addr: got %h cnt=%0d want %h cnt=0", addr, count, BASE); end
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        drive(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'h0);
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || instr !== 32'h20080005 || addr !== BASE) begin tests_failed++; $display("FAIL mid_first: got vld=%b %h @%h want vld=1 20080005 @%h", out_valid, instr, addr, BASE); end
        @(negedge clock);
        tests_run++; if (count !== 16'd1) begin tests_failed++; $display("FAIL mid_count: got %0d want 1", count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_encodings;
        test_backpressure;
        test_illegal;
        test_clear;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
